branch_sequencer: RTL

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer.sv | 89 ++++++++
 1 files changed

// File: rtl/branch_sequencer.sv
// Program-counter sequencer with a two-state fetch/operand FSM for conditional jumps.
// A jump instruction moves to OPER; the operand byte is then either loaded into pc or skipped.
module branch_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] flg_in,
    input  logic       flg_we,
    input  logic       jmp_req,
    input  logic [2:0] cond,
    input  logic       cond_inv,
    input  logic [7:0] imm,
    output logic [7:0] pc,
    output logic [7:0] flags,
    output logic       taken,
    output logic       busy
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_OPER = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_flags;
    logic       r_taken;
    logic       r_busy;
    logic [2:0] r_cond;
    logic       r_cond_inv;

    logic [7:0] w_pc_inc;
    logic       w_hit;

    assign w_pc_inc = r_pc + 8'd1;
    // Evaluated against the registered flags, so a same-edge flag write is not seen.
    assign w_hit    = r_flags[r_cond] ^ r_cond_inv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= 8'h00;
            r_flags    <= 8'h40;
            r_taken    <= 1'b0;
            r_busy     <= 1'b0;
            r_cond     <= 3'd0;
            r_cond_inv <= 1'b0;
        end else begin
            // Bit6 is the "always" flag and bit7 the "never" flag.
            if (flg_we) begin
                r_flags <= {1'b0, 1'b1, flg_in[5:0]};
            end
            r_taken <= 1'b0;
            if (en) begin
                case (r_state)
                    ST_RUN: begin
                        r_pc <= w_pc_inc;
                        if (jmp_req) begin
                            r_cond     <= cond;
                            r_cond_inv <= cond_inv;
                            r_state    <= ST_OPER;
                            r_busy     <= 1'b1;
                        end
                    end
                    ST_OPER: begin
                        if (w_hit) begin
                            r_pc    <= imm;
                            r_taken <= 1'b1;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pc    = r_pc;
    assign flags = r_flags;
    assign taken = r_taken;
    assign busy  = r_busy;

endmodule
